booth_prod_accum: RTL and testbench

- Sequential multiply-accumulate back end that sits directly downstream of the combinational 8x8 Booth multiplier.
- Accepts a stream of signed 16-bit products over a valid/ready handshake and sums a programmed number of them into a wide signed accumulator, saturating on overflow.
- Presents the final sum over a second valid/ready handshake.
- Used for dot products and FIR taps built on the Booth array.

---
 rtl/booth_prod_accum.sv | 111 +++++++++++
 tb/tb_booth_prod_accum.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/booth_prod_accum.sv
// Multiply-accumulate back end for the Booth multiplier: sums a programmed
// number of signed products with saturation and hands the result downstream.
module booth_prod_accum #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              sat_flag,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  state_t                  state;
  state_t                  state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic                    sat;
  logic [LEN_W-1:0]        count;
  logic [LEN_W-1:0]        len_q;
  logic                    xfer;
  logic                    last_xfer;
  logic [ACC_W:0]          add_res;

  // Returns {clamped, value}; overflow shows up as disagreement of the two
  // top bits of the one-bit-wider sum, and the top bit gives the direction.
  function automatic logic [ACC_W:0] sat_add(
    input logic signed [ACC_W-1:0]  a,
    input logic signed [PROD_W-1:0] p
  );
    logic signed [ACC_W:0] a_ext;
    logic signed [ACC_W:0] p_ext;
    logic signed [ACC_W:0] s;
    a_ext = {a[ACC_W-1], a};
    p_ext = {{(ACC_W+1-PROD_W){p[PROD_W-1]}}, p};
    s     = a_ext + p_ext;
    if (s[ACC_W] != s[ACC_W-1])
      sat_add = {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
    else
      sat_add = {1'b0, s[ACC_W-1:0]};
  endfunction

  assign xfer      = (state == ACCUM) && prod_valid;
  assign last_xfer = xfer && ((count + CNT_ONE) == len_q);
  assign add_res   = sat_add(acc, prod);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (last_xfer) state_nxt = DONE;
      end
      DONE: begin
        if (acc_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator stage: result and sticky flag persist in IDLE until next start
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      sat   <= 1'b0;
      count <= '0;
      len_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            sat   <= 1'b0;
            count <= '0;
            len_q <= len;
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc   <= add_res[ACC_W-1:0];
            sat   <= sat | add_res[ACC_W];
            count <= count + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign prod_ready = (state == ACCUM);
  assign acc_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign acc_out    = acc;
  assign sat_flag   = sat;

endmodule

// File: tb/tb_booth_prod_accum.sv
// Scoreboard bench for booth_prod_accum: driver pushes model results, a
// negedge monitor pops them at each result handshake.
module tb_booth_prod_accum;
  localparam int PROD_W = 16;
  localparam int ACC_W  = 18;
  localparam int LEN_W  = 8;
  localparam longint MAXV = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (ACC_W-1));

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic [PROD_W-1:0] prod = '0;
  logic              prod_valid = 1'b0;
  logic              prod_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid;
  logic              acc_ready = 1'b0;
  logic              sat_flag;
  logic              busy;

  int checks = 0;
  int failures = 0;
  logic [ACC_W:0]           exp_q[$];
  logic signed [PROD_W-1:0] prods[$];
  int                       stalls[$];
  logic [ACC_W:0]           mon_e;

  booth_prod_accum #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .acc_out(acc_out),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .sat_flag(sat_flag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && acc_valid && acc_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=none", acc_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_acc", 64'(acc_out), 64'(mon_e[ACC_W-1:0]));
        chk("result_sat", 64'(sat_flag), 64'(mon_e[ACC_W]));
      end
    end
  end

  // Reference: running sum with clamping after every product.
  task automatic run_job(input int n, input int hold, input bit pulse_start);
    longint         a = 0;
    bit             s = 1'b0;
    logic [ACC_W:0] e;
    int             to;
    start = 1'b1;
    len   = n[LEN_W-1:0];
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      prod_valid = 1'b0;
      repeat (stalls[i]) begin @(posedge clk); #1; end
      prod_valid = 1'b1;
      prod = prods[i];
      to = 0;
      while (!prod_ready && to < 20) begin @(posedge clk); #1; to++; end
      if (!prod_ready) begin
        chk("prod_ready_timeout", 64'(prod_ready), 64'd1);
        prod_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      a = a + longint'(prods[i]);
      if (a > MAXV) begin a = MAXV; s = 1'b1; end
      else if (a < MINV) begin a = MINV; s = 1'b1; end
    end
    prod_valid = 1'b0;
    e = {s, a[ACC_W-1:0]};
    exp_q.push_back(e);
    chk("latency_valid", 64'(acc_valid), 64'd1);
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 64'(acc_valid), 64'd1);
      chk("hold_acc", 64'(acc_out), 64'(e[ACC_W-1:0]));
      if (pulse_start) begin start = 1'b1; len = 8'd3; end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("busy_in_done", 64'(busy), 64'd1);
    acc_ready = 1'b1;
    @(posedge clk); #1;
    acc_ready = 1'b0;
    chk("idle_valid", 64'(acc_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_acc_kept", 64'(acc_out), 64'(e[ACC_W-1:0]));
    chk("idle_sat_kept", 64'(sat_flag), 64'(s));
  endtask

  task automatic load(input int n, input logic signed [PROD_W-1:0] p, input int st);
    prods.delete();
    stalls.delete();
    for (int i = 0; i < n; i++) begin
      prods.push_back(p);
      stalls.push_back(st);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_acc", 64'(acc_out), 64'd0);
    chk("rst_valid", 64'(acc_valid), 64'd0);
    chk("rst_ready", 64'(prod_ready), 64'd0);
    chk("rst_sat", 64'(sat_flag), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // reset in the middle of an accumulation
    start = 1'b1; len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0; prod_valid = 1'b1; prod = 16'h7FFF;
    repeat (3) begin @(posedge clk); #1; end
    prod_valid = 1'b0; rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    chk("midrst_acc", 64'(acc_out), 64'd0);
    chk("midrst_valid", 64'(acc_valid), 64'd0);
    chk("midrst_ready", 64'(prod_ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_sat", 64'(sat_flag), 64'd0);

    // basic back-to-back sum: 50 + 60
    load(2, 16'sh0032, 0);
    prods[1] = 16'sh003C;
    run_job(2, 0, 1'b0);

    // signed values with a two-cycle stall: -10 + 100 - 200
    load(3, 16'shFFF6, 0);
    prods[1] = 16'sh0064; prods[2] = 16'shFF38; stalls[1] = 2;
    run_job(3, 1, 1'b0);

    // positive then negative saturation
    load(5, 16'sh7FFF, 0);
    run_job(5, 0, 1'b0);
    load(5, -16'sh8000, 0);
    run_job(5, 0, 1'b0);

    // held result with ignored start pulses, then len=0
    load(1, 16'sh0005, 0);
    run_job(1, 4, 1'b1);
    prods.delete(); stalls.delete();
    run_job(0, 1, 1'b0);

    // randomized jobs
    for (int j = 0; j < 25; j++) begin
      int n;
      n = $urandom_range(1, 12);
      prods.delete(); stalls.delete();
      for (int i = 0; i < n; i++) begin
        prods.push_back(PROD_W'($urandom));
        stalls.push_back($urandom_range(0, 2));
      end
      run_job(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // maximum length, small products so saturation is not guaranteed
    prods.delete(); stalls.delete();
    for (int i = 0; i < 255; i++) begin
      prods.push_back(PROD_W'($urandom_range(0, 1023)) - 16'sd512);
      stalls.push_back(0);
    end
    run_job(255, 0, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
